// File: rtl/apb_instr_buffer_pkg.sv
// Address map, decode enum and sizing defaults shared by the instruction buffer slice.
// Latency: n/a (types, constants and a pure decode function).
// Backpressure: n/a.
package instr_buf_pkg;

  localparam logic [7:0] ADDR_INSTR  = 8'h00;
  localparam logic [7:0] ADDR_RESULT = 8'h04;
  localparam logic [7:0] ADDR_STATUS = 8'h08;

  localparam int DEFAULT_DEPTH  = 8;
  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    DEC_INSTR,
    DEC_RESULT,
    DEC_STATUS,
    DEC_NONE
  } dec_e;

  function automatic dec_e addr_decode(input logic [7:0] addr);
    case (addr)
      ADDR_INSTR:  return DEC_INSTR;
      ADDR_RESULT: return DEC_RESULT;
      ADDR_STATUS: return DEC_STATUS;
      default:     return DEC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/apb_instr_buffer_if.sv
// APB-slave-side register port: address/data/direction/access strobe in, read data and errors out.
// Latency: n/a (wires only).
// Backpressure: none; errors are reported combinationally through write_error/read_error.
interface apb_instr_buffer_if;
  logic [31:0] address_bus;
  logic [31:0] data_bus;
  logic        write_instr;
  logic        valid_data;
  logic [31:0] output_data;
  logic        write_error;
  logic        read_error;

  modport master (
    output address_bus, data_bus, write_instr, valid_data,
    input  output_data, write_error, read_error
  );

  modport slave (
    input  address_bus, data_bus, write_instr, valid_data,
    output output_data, write_error, read_error
  );
endinterface

// File: rtl/apb_instr_buffer_fifo.sv
// Generic synchronous FIFO (instr_fifo): push/pop with full, empty and occupancy count.
// Latency: pushed word visible at pop_dat one cycle after the push edge; pop_dat reads 0 while empty.
// Backpressure: push ignored when full, pop ignored when empty; both may happen in one cycle.
module instr_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_dat,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/apb_instr_buffer.sv
// APB register/decode stage: pushes INSTR writes into a FIFO, holds the latest FP result for reads.
// Latency: one action per transfer on the valid_data rising edge; push/result clear visible next cycle.
// Backpressure: full FIFO or bad address raises write_error/read_error; STATUS at 0x08 with INSTR_BUF_STATUS_EN.
module apb_instr_buffer
  import instr_buf_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              nrst,
  apb_instr_buffer_if.slave apb,
  output logic [DATA_W-1:0] instr_data,
  output logic              instr_empty,
  input  logic              instr_pop,
  input  logic [DATA_W-1:0] result_in,
  input  logic              result_strobe
);

  localparam int CW = $clog2(DEPTH) + 1;

  dec_e              dec;
  logic              valid_d;
  logic              accept;
  logic              push;
  logic              consume;
  logic              status_ok;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [DATA_W-1:0] push_dat;
  logic [DATA_W-1:0] result_reg;
  logic              result_valid;
  logic              addr_unused;

  assign dec         = addr_decode(apb.address_bus[7:0]);
  assign addr_unused = ^apb.address_bus[31:8];

  // valid_data may stay high for many cycles; only its rising edge acts.
  assign accept = apb.valid_data & ~valid_d;

`ifdef INSTR_BUF_STATUS_EN
  logic        overrun;
  logic [31:0] status_word;
  assign status_ok   = (dec == DEC_STATUS);
  assign status_word = {16'h0, 8'(fifo_count), 4'h0, overrun, result_valid, fifo_full, fifo_empty};
`else
  logic count_unused;
  assign status_ok    = 1'b0;
  assign count_unused = ^fifo_count;
`endif

  assign apb.write_error = apb.write_instr & ((dec != DEC_INSTR) | fifo_full);
  assign apb.read_error  = ~apb.write_instr &
                           ((dec == DEC_RESULT) ? ~result_valid : ~status_ok);

  assign push     = accept & apb.write_instr & ~apb.write_error;
  assign consume  = accept & ~apb.write_instr & (dec == DEC_RESULT) & result_valid;
  assign push_dat = DATA_W'(apb.data_bus);

  always_comb begin
    apb.output_data = '0;
    case (dec)
      DEC_RESULT: apb.output_data = 32'(result_reg);
`ifdef INSTR_BUF_STATUS_EN
      DEC_STATUS: apb.output_data = status_word;
`endif
      default:    apb.output_data = '0;
    endcase
  end

  // A strobe landing on the same edge as a consuming read keeps the new result valid.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid_d      <= 1'b0;
      result_reg   <= '0;
      result_valid <= 1'b0;
    end else begin
      valid_d <= apb.valid_data;
      if (result_strobe) begin
        result_reg   <= result_in;
        result_valid <= 1'b1;
      end else if (consume) begin
        result_valid <= 1'b0;
      end
    end
  end

`ifdef INSTR_BUF_STATUS_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) overrun <= 1'b0;
    else       overrun <= overrun | (result_strobe & result_valid & ~consume);
  end
`endif

  instr_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk      (clk),
    .nrst     (nrst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (instr_pop),
    .pop_dat  (instr_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign instr_empty = fifo_empty;

endmodule

// File: tb/tb_apb_instr_buffer.sv
// Directed bench for apb_instr_buffer: decode/error vector table plus multi-cycle sequences.
// STATUS expectations follow INSTR_BUF_STATUS_EN when the bench is built with it.
module tb_apb_instr_buffer;

`ifdef INSTR_BUF_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic        clk;
  logic        nrst;
  logic [31:0] instr_data;
  logic        instr_empty;
  logic        instr_pop;
  logic [31:0] result_in;
  logic        result_strobe;

  apb_instr_buffer_if bus();

  apb_instr_buffer #(.DEPTH(8), .DATA_W(32)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .apb           (bus),
    .instr_data    (instr_data),
    .instr_empty   (instr_empty),
    .instr_pop     (instr_pop),
    .result_in     (result_in),
    .result_strobe (result_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] dat;
    logic        exp_werr;
    logic        exp_rerr;
    logic [31:0] exp_out;
  } vec_t;

  vec_t        vecs[10];
  int          n_pass = 0;
  int          n_total = 0;
  logic        werr;
  logic        rerr;
  logic [31:0] od;
  logic [31:0] fill_w[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    else n_pass++;
  endtask

  // Starts just after a rising edge; samples the combinational outputs before the accept edge.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input int hold,
                      output logic we, output logic re, output logic [31:0] o);
    bus.address_bus = a;
    bus.data_bus    = d;
    bus.write_instr = w;
    bus.valid_data  = 1'b1;
    #1;
    we = bus.write_error;
    re = bus.read_error;
    o  = bus.output_data;
    repeat (hold) @(posedge clk);
    #1;
    bus.valid_data = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_pop();
    instr_pop = 1'b1;
    @(posedge clk);
    #1;
    instr_pop = 1'b0;
  endtask

  task automatic strobe(input logic [31:0] v);
    result_in     = v;
    result_strobe = 1'b1;
    @(posedge clk);
    #1;
    result_strobe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0000_0000, 1'b1, 32'hA1A1_0001, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{32'h0000_0004, 1'b1, 32'hBAD0_0004, 1'b1, 1'b0, 32'h0};
    vecs[2] = '{32'h0000_0008, 1'b1, 32'hBAD0_0008, 1'b1, 1'b0, 32'h0};
    vecs[3] = '{32'h0000_0010, 1'b1, 32'hBAD0_0010, 1'b1, 1'b0, 32'h0};
    vecs[4] = '{32'h0000_0004, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0};
    vecs[5] = '{32'h0000_0000, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0};
    vecs[6] = '{32'h0000_0008, 1'b0, 32'h0,         1'b0, !STATUS_EN, STATUS_EN ? 32'h0000_0100 : 32'h0};
    vecs[7] = '{32'h0000_0100, 1'b1, 32'hA2A2_0002, 1'b0, 1'b0, 32'h0};
    vecs[8] = '{32'hFFFF_FF04, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0};
    vecs[9] = '{32'h0000_0108, 1'b1, 32'hBAD0_0108, 1'b1, 1'b0, 32'h0};
    for (int i = 0; i < 8; i++) fill_w[i] = 32'h1000_0000 + 32'(i) * 32'h111;

    nrst             = 1'b0;
    bus.address_bus  = 32'h4;
    bus.data_bus     = 32'h0;
    bus.write_instr  = 1'b0;
    bus.valid_data   = 1'b0;
    instr_pop        = 1'b0;
    result_in        = 32'h0;
    result_strobe    = 1'b0;
    #2;
    chk("rst_empty", instr_empty, 32'd1);
    chk("rst_instr_data", instr_data, 32'h0);
    chk("rst_output_data", bus.output_data, 32'h0);
    chk("rst_result_rerr", bus.read_error, 32'd1);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;

    // Long ACCESS phase must push exactly once.
    bus.address_bus = 32'h0;
    bus.data_bus    = 32'h3F80_0000;
    bus.write_instr = 1'b1;
    bus.valid_data  = 1'b1;
    #1;
    chk("hold_werr", bus.write_error, 32'd0);
    @(posedge clk); #1;
    chk("hold_data", instr_data, 32'h3F80_0000);
    chk("hold_nempty", instr_empty, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    bus.valid_data = 1'b0;
    @(posedge clk); #1;
    if (STATUS_EN) begin
      xfer(32'h8, 1'b0, 32'h0, 1, werr, rerr, od);
      chk("hold_status_count1", od, 32'h0000_0100);
    end
    do_pop();
    chk("hold_single_push", instr_empty, 32'd1);

    for (int i = 0; i < 10; i++) begin
      xfer(vecs[i].addr, vecs[i].wr, vecs[i].dat, 1, werr, rerr, od);
      chk($sformatf("vec%0d_werr", i), werr, 32'(vecs[i].exp_werr));
      chk($sformatf("vec%0d_rerr", i), rerr, 32'(vecs[i].exp_rerr));
      chk($sformatf("vec%0d_out", i), od, vecs[i].exp_out);
    end
    chk("vec_head0", instr_data, 32'hA1A1_0001);
    do_pop();
    chk("vec_head1", instr_data, 32'hA2A2_0002);
    do_pop();
    chk("vec_drained", instr_empty, 32'd1);

    for (int i = 0; i < 8; i++) begin
      xfer(32'h0, 1'b1, fill_w[i], 1, werr, rerr, od);
      chk($sformatf("fill%0d_werr", i), werr, 32'd0);
    end
    if (STATUS_EN) begin
      xfer(32'h8, 1'b0, 32'h0, 1, werr, rerr, od);
      chk("fill_status_full", od, 32'h0000_0802);
    end
    xfer(32'h0, 1'b1, 32'hDEAD_BEEF, 1, werr, rerr, od);
    chk("overflow_werr", werr, 32'd1);
    chk("overflow_head", instr_data, fill_w[0]);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_data", i), instr_data, fill_w[i]);
      do_pop();
    end
    chk("drain_empty", instr_empty, 32'd1);

    // Push with pop while empty: pop ignored, push lands.
    bus.address_bus = 32'h0;
    bus.data_bus    = 32'h55AA_55AA;
    bus.write_instr = 1'b1;
    bus.valid_data  = 1'b1;
    instr_pop       = 1'b1;
    @(posedge clk); #1;
    instr_pop = 1'b0;
    chk("pp_empty_nempty", instr_empty, 32'd0);
    chk("pp_empty_data", instr_data, 32'h55AA_55AA);
    bus.valid_data = 1'b0;
    @(posedge clk); #1;
    do_pop();
    chk("pp_empty_drained", instr_empty, 32'd0 + 32'd1);

    // Push with pop on a one-entry FIFO: occupancy unchanged.
    xfer(32'h0, 1'b1, 32'h0000_000A, 1, werr, rerr, od);
    bus.data_bus   = 32'h0000_000B;
    bus.valid_data = 1'b1;
    instr_pop      = 1'b1;
    @(posedge clk); #1;
    instr_pop      = 1'b0;
    bus.valid_data = 1'b0;
    chk("pp_mid_data", instr_data, 32'h0000_000B);
    @(posedge clk); #1;
    do_pop();
    chk("pp_mid_drained", instr_empty, 32'd1);

    strobe(32'h4049_0FDB);
    xfer(32'h4, 1'b0, 32'h0, 1, werr, rerr, od);
    chk("res_rd1_rerr", rerr, 32'd0);
    chk("res_rd1_out", od, 32'h4049_0FDB);
    xfer(32'h4, 1'b0, 32'h0, 1, werr, rerr, od);
    chk("res_rd2_rerr", rerr, 32'd1);
    chk("res_rd2_out", od, 32'h4049_0FDB);

    // Strobe on the same edge as a consuming read: new result stays valid.
    strobe(32'h0000_0033);
    bus.address_bus = 32'h4;
    bus.write_instr = 1'b0;
    bus.valid_data  = 1'b1;
    result_in       = 32'h0000_0044;
    result_strobe   = 1'b1;
    #1;
    chk("coll_rerr", bus.read_error, 32'd0);
    chk("coll_out", bus.output_data, 32'h0000_0033);
    @(posedge clk); #1;
    result_strobe  = 1'b0;
    bus.valid_data = 1'b0;
    @(posedge clk); #1;
    xfer(32'h4, 1'b0, 32'h0, 1, werr, rerr, od);
    chk("coll_after_rerr", rerr, 32'd0);
    chk("coll_after_out", od, 32'h0000_0044);
    xfer(32'h8, 1'b0, 32'h0, 1, werr, rerr, od);
    chk("coll_status_rerr", rerr, 32'(!STATUS_EN));
    chk("coll_status_out", od, STATUS_EN ? 32'h0000_0001 : 32'h0);

    strobe(32'h1111_1111);
    strobe(32'h2222_2222);
    xfer(32'h8, 1'b0, 32'h0, 1, werr, rerr, od);
    chk("ovr_status_rerr", rerr, 32'(!STATUS_EN));
    chk("ovr_status_out", od, STATUS_EN ? 32'h0000_000D : 32'h0);
    xfer(32'h4, 1'b0, 32'h0, 1, werr, rerr, od);
    chk("ovr_result_out", od, 32'h2222_2222);
    xfer(32'h8, 1'b0, 32'h0, 1, werr, rerr, od);
    chk("ovr_sticky_out", od, STATUS_EN ? 32'h0000_0009 : 32'h0);

    // Async reset in the middle of an ACCESS phase with three words queued.
    for (int i = 0; i < 3; i++) xfer(32'h0, 1'b1, 32'h7000_0000 + 32'(i), 1, werr, rerr, od);
    bus.address_bus = 32'h0;
    bus.data_bus    = 32'h7777_7777;
    bus.write_instr = 1'b1;
    bus.valid_data  = 1'b1;
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_empty", instr_empty, 32'd1);
    chk("arst_data", instr_data, 32'h0);
    bus.valid_data = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    xfer(32'h4, 1'b0, 32'h0, 1, werr, rerr, od);
    chk("arst_result_rerr", rerr, 32'd1);
    chk("arst_result_out", od, 32'h0);
    if (STATUS_EN) begin
      xfer(32'h8, 1'b0, 32'h0, 1, werr, rerr, od);
      chk("arst_status_out", od, 32'h0000_0001);
    end
    xfer(32'h0, 1'b1, 32'hCAFE_F00D, 2, werr, rerr, od);
    chk("post_rst_werr", werr, 32'd0);
    chk("post_rst_data", instr_data, 32'hCAFE_F00D);
    do_pop();
    chk("post_rst_single", instr_empty, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
